// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS control path: state encodings,
// opcodes, ALU_op codes (also used by ALUcontrol) and datapath mux selects.
package mips_ctrl_pkg;

    typedef logic [3:0] state_t;

    localparam state_t ST_FETCH  = 4'd0;
    localparam state_t ST_DECODE = 4'd1;
    localparam state_t ST_MEMADR = 4'd2;
    localparam state_t ST_MEMRD  = 4'd3;
    localparam state_t ST_MEMWB  = 4'd4;
    localparam state_t ST_MEMWR  = 4'd5;
    localparam state_t ST_EXEC   = 4'd6;
    localparam state_t ST_ALUWB  = 4'd7;
    localparam state_t ST_BRANCH = 4'd8;
    localparam state_t ST_ADDIEX = 4'd9;
    localparam state_t ST_IWB    = 4'd10;
    localparam state_t ST_JUMP   = 4'd11;
    localparam state_t ST_ANDIEX = 4'd12;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10,
        ALU_AND   = 2'b11
    } alu_op_e;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_J     = 6'b000010;

    function automatic logic opcode_legal(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_ANDI) ||
               (op == OP_J);
    endfunction

endpackage

// File: rtl/ctrl_output_decode.sv
// Combinational map from FSM state (plus mem_ready in FETCH) to every
// datapath control line; unlisted signals default to 0.
module ctrl_output_decode
    import mips_ctrl_pkg::*;
(
    input  logic [3:0] state_i,
    input  logic       mem_ready_i,
    output logic [1:0] alu_op_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] pc_src_o,
    output logic       pc_write_o,
    output logic       pc_write_cond_o,
    output logic       i_or_d_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       ir_write_o,
    output logic       reg_dst_o,
    output logic       mem_to_reg_o,
    output logic       reg_write_o
);

    always_comb begin
        alu_op_o        = ALU_ADD;
        alu_src_a_o     = 1'b0;
        alu_src_b_o     = SRCB_REG;
        pc_src_o        = PCSRC_ALU;
        pc_write_o      = 1'b0;
        pc_write_cond_o = 1'b0;
        i_or_d_o        = 1'b0;
        mem_read_o      = 1'b0;
        mem_write_o     = 1'b0;
        ir_write_o      = 1'b0;
        reg_dst_o       = 1'b0;
        mem_to_reg_o    = 1'b0;
        reg_write_o     = 1'b0;
        case (state_i)
            ST_FETCH: begin
                mem_read_o  = 1'b1;
                alu_src_b_o = SRCB_FOUR;
                // IR and PC+4 commit only in the cycle memory delivers the word
                ir_write_o  = mem_ready_i;
                pc_write_o  = mem_ready_i;
            end
            ST_DECODE: alu_src_b_o = SRCB_IMM_SH2;
            ST_MEMADR, ST_ADDIEX: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRCB_IMM;
            end
            ST_ANDIEX: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRCB_IMM;
                alu_op_o    = ALU_AND;
            end
            ST_MEMRD: begin
                mem_read_o = 1'b1;
                i_or_d_o   = 1'b1;
            end
            ST_MEMWR: begin
                mem_write_o = 1'b1;
                i_or_d_o    = 1'b1;
            end
            ST_MEMWB: begin
                mem_to_reg_o = 1'b1;
                reg_write_o  = 1'b1;
            end
            ST_EXEC: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = ALU_FUNCT;
            end
            ST_ALUWB: begin
                reg_dst_o   = 1'b1;
                reg_write_o = 1'b1;
            end
            ST_IWB: reg_write_o = 1'b1;
            ST_BRANCH: begin
                alu_src_a_o     = 1'b1;
                alu_op_o        = ALU_SUB;
                pc_src_o        = PCSRC_ALUOUT;
                pc_write_cond_o = 1'b1;
            end
            ST_JUMP: begin
                pc_src_o   = PCSRC_JUMP;
                pc_write_o = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath: state register, opcode
// latch and next-state logic; control lines come from ctrl_output_decode.
//
//   state  | meaning
//   FETCH  | read instruction at PC, PC+4 when mem_ready
//   DECODE | latch opcode, precompute branch target, dispatch
//   MEMADR | compute lw/sw effective address
//   MEMRD  | data read, wait for mem_ready
//   MEMWB  | write MDR to rt
//   MEMWR  | data write, wait for mem_ready
//   EXEC   | R-type ALU operation
//   ALUWB  | write ALUOut to rd
//   BRANCH | beq compare and conditional PC load
//   ADDIEX | addi ALU operation
//   IWB    | write ALUOut to rt
//   JUMP   | load jump target
//   ANDIEX | andi ALU operation
module multicycle_control
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic [1:0] ALU_op,
    output logic       ALU_src_A,
    output logic [1:0] ALU_src_B,
    output logic [1:0] PC_src,
    output logic       PC_write,
    output logic       PC_write_cond,
    output logic       I_or_D,
    output logic       mem_read,
    output logic       mem_write,
    output logic       IR_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_t     state_q, state_d;
    logic [5:0] opcode_q, opcode_d;

    logic [1:0] dec_alu_op, dec_alu_src_b, dec_pc_src;
    logic       dec_alu_src_a, dec_pc_write, dec_pc_write_cond, dec_i_or_d;
    logic       dec_mem_read, dec_mem_write, dec_ir_write;
    logic       dec_reg_dst, dec_mem_to_reg, dec_reg_write;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_FETCH;
            opcode_q <= 6'd0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
        end
    end

    assign opcode_d = (state_q == ST_DECODE) ? opcode : opcode_q;

    always_comb begin
        state_d = ST_FETCH;
        case (state_q)
            ST_FETCH: state_d = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_d = ST_EXEC;
                    OP_LW, OP_SW: state_d = ST_MEMADR;
                    OP_BEQ:       state_d = ST_BRANCH;
                    OP_ADDI:      state_d = ST_ADDIEX;
                    OP_ANDI:      state_d = ST_ANDIEX;
                    OP_J:         state_d = ST_JUMP;
                    default:      state_d = ST_FETCH;
                endcase
            end
            ST_MEMADR: state_d = (opcode_q == OP_SW) ? ST_MEMWR : ST_MEMRD;
            ST_MEMRD:  state_d = mem_ready ? ST_MEMWB : ST_MEMRD;
            ST_MEMWR:  state_d = mem_ready ? ST_FETCH : ST_MEMWR;
            ST_EXEC:   state_d = ST_ALUWB;
            ST_ADDIEX, ST_ANDIEX: state_d = ST_IWB;
            default:   state_d = ST_FETCH;
        endcase
    end

    ctrl_output_decode u_decode (
        .state_i         (state_q),
        .mem_ready_i     (mem_ready),
        .alu_op_o        (dec_alu_op),
        .alu_src_a_o     (dec_alu_src_a),
        .alu_src_b_o     (dec_alu_src_b),
        .pc_src_o        (dec_pc_src),
        .pc_write_o      (dec_pc_write),
        .pc_write_cond_o (dec_pc_write_cond),
        .i_or_d_o        (dec_i_or_d),
        .mem_read_o      (dec_mem_read),
        .mem_write_o     (dec_mem_write),
        .ir_write_o      (dec_ir_write),
        .reg_dst_o       (dec_reg_dst),
        .mem_to_reg_o    (dec_mem_to_reg),
        .reg_write_o     (dec_reg_write)
    );

    // Reset blanks every control line combinationally, not just at the next edge
    assign ALU_op        = dec_alu_op & {2{~reset}};
    assign ALU_src_A     = dec_alu_src_a & ~reset;
    assign ALU_src_B     = dec_alu_src_b & {2{~reset}};
    assign PC_src        = dec_pc_src & {2{~reset}};
    assign PC_write      = dec_pc_write & ~reset;
    assign PC_write_cond = dec_pc_write_cond & ~reset;
    assign I_or_D        = dec_i_or_d & ~reset;
    assign mem_read      = dec_mem_read & ~reset;
    assign mem_write     = dec_mem_write & ~reset;
    assign IR_write      = dec_ir_write & ~reset;
    assign reg_dst       = dec_reg_dst & ~reset;
    assign mem_to_reg    = dec_mem_to_reg & ~reset;
    assign reg_write     = dec_reg_write & ~reset;
    assign illegal_op    = ~reset && (state_q == ST_DECODE) && !opcode_legal(opcode);
    assign state         = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized instruction stream checked cycle by cycle against a phase-list
// model of the control FSM through an expected-value queue.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic [1:0] ALU_op, ALU_src_B, PC_src;
    logic       ALU_src_A, PC_write, PC_write_cond, I_or_D, mem_read, mem_write;
    logic       IR_write, reg_dst, mem_to_reg, reg_write, illegal_op;
    logic [3:0] state;

    int checks = 0;
    int failures = 0;
    bit mon_en = 1'b0;
    logic [20:0] exp_q[$];

    multicycle_control dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .ALU_op(ALU_op), .ALU_src_A(ALU_src_A), .ALU_src_B(ALU_src_B),
        .PC_src(PC_src), .PC_write(PC_write), .PC_write_cond(PC_write_cond),
        .I_or_D(I_or_D), .mem_read(mem_read), .mem_write(mem_write),
        .IR_write(IR_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    logic [5:0] legal_ops[7] = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h08, 6'h0c, 6'h02};

    function automatic bit is_legal(input logic [5:0] op);
        foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    // Packing: {ALU_op, src_A, src_B, PC_src, PC_write, PC_write_cond, I_or_D,
    //           mem_read, mem_write, IR_write, reg_dst, mem_to_reg, reg_write, illegal, state}
    function automatic logic [20:0] exp_out(input int st, input bit mr, input bit ill);
        logic [1:0] aop = 0, sb = 0, ps = 0;
        logic sa = 0, pw = 0, pwc = 0, iod = 0, mrd = 0, mwr = 0, irw = 0, rd = 0, m2r = 0, rw = 0;
        logic [3:0] s4 = 4'(st);
        case (st)
            0:  begin mrd = 1; sb = 2'b01; irw = mr; pw = mr; end
            1:  sb = 2'b11;
            2, 9: begin sa = 1; sb = 2'b10; end
            12: begin sa = 1; sb = 2'b10; aop = 2'b11; end
            3:  begin mrd = 1; iod = 1; end
            5:  begin mwr = 1; iod = 1; end
            4:  begin m2r = 1; rw = 1; end
            6:  begin sa = 1; aop = 2'b10; end
            7:  begin rd = 1; rw = 1; end
            10: rw = 1;
            8:  begin sa = 1; aop = 2'b01; ps = 2'b01; pwc = 1; end
            11: begin ps = 2'b10; pw = 1; end
            default: ;
        endcase
        return {aop, sa, sb, ps, pw, pwc, iod, mrd, mwr, irw, rd, m2r, rw, ill, s4};
    endfunction

    function automatic logic [20:0] act_out();
        return {ALU_op, ALU_src_A, ALU_src_B, PC_src, PC_write, PC_write_cond, I_or_D,
                mem_read, mem_write, IR_write, reg_dst, mem_to_reg, reg_write, illegal_op, state};
    endfunction

    task automatic check(input string name, input logic [20:0] act, input logic [20:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && exp_q.size() > 0) begin
            logic [20:0] e;
            e = exp_q.pop_front();
            check("cycle", act_out(), e);
            checks++;
            if (mem_write && reg_write) begin
                failures++;
                $display("FAIL wr_excl t=%0t actual=both expected=not both", $time);
            end
        end
    end

    // Called just after a rising edge; drives one cycle and records its expectation.
    task automatic drive_cycle(input int st, input bit mr, input logic [5:0] op, input bit ill);
        mem_ready = mr;
        opcode = op;
        exp_q.push_back(exp_out(st, mr, ill));
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] junk();
        return 6'($urandom_range(0, 63));
    endfunction

    task automatic run_instr(input logic [5:0] op, input int fix_wait);
        int steps[$];
        int w;
        case (op)
            6'h00:   steps = '{0, 1, 6, 7};
            6'h23:   steps = '{0, 1, 2, 3, 4};
            6'h2b:   steps = '{0, 1, 2, 5};
            6'h04:   steps = '{0, 1, 8};
            6'h08:   steps = '{0, 1, 9, 10};
            6'h0c:   steps = '{0, 1, 12, 10};
            6'h02:   steps = '{0, 1, 11};
            default: steps = '{0, 1};
        endcase
        foreach (steps[k]) begin
            if (steps[k] == 0 || steps[k] == 3 || steps[k] == 5) begin
                if (fix_wait >= 0) w = (steps[k] == 0) ? 0 : fix_wait;
                else w = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
                repeat (w) drive_cycle(steps[k], 1'b0, junk(), 1'b0);
                drive_cycle(steps[k], 1'b1, junk(), 1'b0);
            end else if (steps[k] == 1) begin
                drive_cycle(1, 1'($urandom_range(0, 1)), op, !is_legal(op));
            end else begin
                drive_cycle(steps[k], 1'($urandom_range(0, 1)), junk(), 1'b0);
            end
        end
    endtask

    initial begin
        logic [5:0] op;
        reset = 1'b1;
        mem_ready = 1'b1;
        opcode = 6'h00;
        #3;
        check("reset_state", act_out(), 21'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        mon_en = 1'b1;

        run_instr(6'h00, 0);
        run_instr(6'h23, 2);
        run_instr(6'h04, 0);
        run_instr(6'h02, 0);
        run_instr(6'h0c, 0);
        run_instr(6'h08, 0);
        run_instr(6'h2b, 1);
        run_instr(6'h3f, 0);

        // Abort an lw while it waits in MEMRD
        drive_cycle(0, 1'b1, junk(), 1'b0);
        drive_cycle(1, 1'b1, 6'h23, 1'b0);
        drive_cycle(2, 1'b1, junk(), 1'b0);
        mem_ready = 1'b0;
        exp_q.push_back(exp_out(3, 1'b0, 1'b0));
        @(negedge clk);
        #2;
        mon_en = 1'b0;
        reset = 1'b1;
        #1;
        check("reset_async", act_out(), 21'd0);
        @(posedge clk);
        #1;
        check("reset_hold", act_out(), 21'd0);
        reset = 1'b0;
        #1;
        check("reset_release", act_out(), exp_out(0, 1'b0, 1'b0));
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                do op = junk(); while (is_legal(op));
            end else begin
                op = legal_ops[$urandom_range(0, 6)];
            end
            run_instr(op, -1);
        end

        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain actual=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
